// File: rtl/pipeline_ctrl.sv
// Hazard, forwarding and halt-drain control for a five-stage pipeline.
// Also tracks data-memory wait timeouts and counts PC stall cycles.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT  = 255,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic [4:0]  me_rd,
    input  logic        me_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    input  logic        br_ctrl,
    input  logic        me_mem_req,
    input  logic        dmem_ready,
    input  logic        halt_req,
    output logic [1:0]  forwardA,
    output logic [1:0]  forwardB,
    output logic        pc_stall,
    output logic        if_id_stall,
    output logic        if_id_flush,
    output logic        id_ex_stall,
    output logic        id_ex_flush,
    output logic        ex_me_stall,
    output logic        me_wb_flush,
    output logic        halted,
    output logic        mem_timeout,
    output logic [15:0] stall_cycles
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [DCW-1:0]   drain_q, drain_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic             timeout_q, timeout_d;
    logic [15:0]      stall_q, stall_d;

    logic mem_stall;
    logic load_use;
    logic drain_last;

    assign mem_stall  = me_mem_req && !dmem_ready;
    assign load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                        ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    assign drain_last = (drain_q == DCW'(DRAIN_CYCLES - 1));

    // MEM stage result takes priority over the older WB value.
    always_comb begin
        forwardA = 2'b00;
        forwardB = 2'b00;
        if (me_reg_write && me_rd != 5'd0 && me_rd == ex_rs1)
            forwardA = 2'b10;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs1)
            forwardA = 2'b01;
        if (me_reg_write && me_rd != 5'd0 && me_rd == ex_rs2)
            forwardB = 2'b10;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == ex_rs2)
            forwardB = 2'b01;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            drain_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        unique case (state_q)
            RUN: begin
                if (halt_req && !mem_stall) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (!mem_stall) begin
                    if (drain_last)
                        state_d = HALTED;
                    else
                        drain_d = drain_q + DCW'(1);
                end
            end
            HALTED: begin
                if (!halt_req)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    // Outputs are held idle while rst is asserted, whatever the inputs.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_stall = 1'b0;
        id_ex_flush = 1'b0;
        ex_me_stall = 1'b0;
        me_wb_flush = 1'b0;
        halted      = (state_q == HALTED);
        if (!rst) begin
            if (state_q == HALTED) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                me_wb_flush = 1'b1;
            end else if (mem_stall) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_stall = 1'b1;
                ex_me_stall = 1'b1;
                me_wb_flush = 1'b1;
            end else if (br_ctrl) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (state_q == DRAIN) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_comb begin
        wait_d = '0;
        if (mem_stall) begin
            if (wait_q == WCW'(MEM_TIMEOUT))
                wait_d = wait_q;
            else
                wait_d = wait_q + WCW'(1);
        end
        timeout_d = timeout_q || (wait_d == WCW'(MEM_TIMEOUT));
        stall_d   = stall_q;
        if (pc_stall && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table, corner sequences
// and randomized traffic against a rule-level reference model.
module tb_pipeline_ctrl;

    localparam int MT = 255;
    localparam int DC = 3;
    localparam int ST_RUN = 0;
    localparam int ST_DRN = 1;
    localparam int ST_HLT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic        ex_mem_read;
    logic [4:0]  me_rd, wb_rd;
    logic        me_reg_write, wb_reg_write;
    logic        br_ctrl, me_mem_req, dmem_ready, halt_req;
    logic [1:0]  forwardA, forwardB;
    logic        pc_stall, if_id_stall, if_id_flush;
    logic        id_ex_stall, id_ex_flush, ex_me_stall;
    logic        me_wb_flush, halted, mem_timeout;
    logic [15:0] stall_cycles;

    pipeline_ctrl #(.MEM_TIMEOUT(MT), .DRAIN_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read),
        .me_rd(me_rd), .me_reg_write(me_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .br_ctrl(br_ctrl), .me_mem_req(me_mem_req),
        .dmem_ready(dmem_ready), .halt_req(halt_req),
        .forwardA(forwardA), .forwardB(forwardB),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_me_stall(ex_me_stall),
        .me_wb_flush(me_wb_flush), .halted(halted),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] me_rd, wb_rd, ex_rs1, ex_rs2;
        logic [4:0] ex_rd, id_rs1, id_rs2;
        logic       me_w, wb_w, ex_mr, br, mreq, rdy, halt;
    } in_t;

    typedef struct {
        in_t         v;
        logic [11:0] exp;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    int m_st, m_drained, m_wait, m_stalls;
    bit m_to;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h @%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t v;
        v.me_rd = 0; v.wb_rd = 0; v.ex_rs1 = 0; v.ex_rs2 = 0;
        v.ex_rd = 0; v.id_rs1 = 0; v.id_rs2 = 0;
        v.me_w = 0; v.wb_w = 0; v.ex_mr = 0; v.br = 0;
        v.mreq = 0; v.rdy = 1; v.halt = 0;
        return v;
    endfunction

    function automatic in_t mk(
        input logic [4:0] mrd, input logic mw,
        input logic [4:0] wrd, input logic ww,
        input logic [4:0] e1, input logic [4:0] e2,
        input logic emr, input logic [4:0] erd,
        input logic [4:0] i1, input logic [4:0] i2,
        input logic b, input logic mq, input logic rd);
        in_t v = idle();
        v.me_rd = mrd; v.me_w = mw; v.wb_rd = wrd; v.wb_w = ww;
        v.ex_rs1 = e1; v.ex_rs2 = e2; v.ex_mr = emr; v.ex_rd = erd;
        v.id_rs1 = i1; v.id_rs2 = i2; v.br = b;
        v.mreq = mq; v.rdy = rd;
        return v;
    endfunction

    function automatic logic [1:0] mfwd(input in_t v,
                                        input logic [4:0] rs);
        if (v.me_w && v.me_rd != 0 && v.me_rd == rs) return 2'b10;
        if (v.wb_w && v.wb_rd != 0 && v.wb_rd == rs) return 2'b01;
        return 2'b00;
    endfunction

    // {pc,ifs,iff,ids,idf,exs,mwf,halted}
    function automatic logic [7:0] mctl(input in_t v);
        bit ms = v.mreq && !v.rdy;
        bit lu = v.ex_mr && v.ex_rd != 0 &&
                 (v.ex_rd == v.id_rs1 || v.ex_rd == v.id_rs2);
        if (m_st == ST_HLT) return 8'b1010_1011;
        if (ms) return 8'b1101_0110;
        if (v.br) return 8'b0010_1000;
        if (m_st == ST_DRN) return 8'b1010_0000;
        if (lu) return 8'b1100_1000;
        return 8'b0;
    endfunction

    function automatic logic [11:0] mout(input in_t v);
        return {mfwd(v, v.ex_rs1), mfwd(v, v.ex_rs2), mctl(v)};
    endfunction

    function automatic logic [11:0] dout();
        return {forwardA, forwardB, pc_stall, if_id_stall,
                if_id_flush, id_ex_stall, id_ex_flush,
                ex_me_stall, me_wb_flush, halted};
    endfunction

    task automatic drive(input in_t v);
        me_rd = v.me_rd; wb_rd = v.wb_rd;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
        me_reg_write = v.me_w; wb_reg_write = v.wb_w;
        ex_mem_read = v.ex_mr; br_ctrl = v.br;
        me_mem_req = v.mreq; dmem_ready = v.rdy;
        halt_req = v.halt;
    endtask

    task automatic model_reset();
        m_st = ST_RUN; m_drained = 0; m_wait = 0;
        m_stalls = 0; m_to = 0;
    endtask

    task automatic apply(input in_t v, input string nm);
        drive(v);
        @(negedge clk);
        chk({nm, "_ctl"}, 32'(dout()), 32'(mout(v)));
        chk({nm, "_cnt"}, {15'd0, mem_timeout, stall_cycles},
            {15'd0, m_to, 16'(m_stalls)});
    endtask

    task automatic tick(input in_t v);
        bit ms = v.mreq && !v.rdy;
        logic [7:0] c = mctl(v);
        @(posedge clk);
        if (c[7] && m_stalls < 65535) m_stalls++;
        m_wait = ms ? ((m_wait < MT) ? m_wait + 1 : MT) : 0;
        if (m_wait == MT) m_to = 1;
        case (m_st)
            ST_RUN: if (v.halt && !ms) begin
                m_st = ST_DRN; m_drained = 0;
            end
            ST_DRN: if (!ms) begin
                m_drained++;
                if (m_drained == DC) m_st = ST_HLT;
            end
            default: if (!v.halt) m_st = ST_RUN;
        endcase
        #1;
    endtask

    task automatic cyc(input in_t v, input string nm);
        apply(v, nm);
        tick(v);
    endtask

    task automatic do_reset();
        in_t v = mk(5'd1, 1'b1, 5'd2, 1'b1, 5'd1, 5'd2, 1'b1,
                    5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 1'b0);
        v.halt = 1;
        rst = 1'b1;
        drive(v);
        @(negedge clk);
        chk("rst_ctl", 32'(dout() & 12'h0FF), 32'd0);
        chk("rst_cnt", {15'd0, mem_timeout, stall_cycles}, 32'd0);
        model_reset();
        drive(idle());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    vec_t tv[9];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t v;
        tv[0].v = mk(7, 1, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        tv[0].exp = {2'b10, 2'b00, 8'h00};
        tv[1].v = mk(7, 0, 7, 1, 7, 0, 0, 0, 0, 0, 0, 0, 1);
        tv[1].exp = {2'b01, 2'b00, 8'h00};
        tv[2].v = mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        tv[2].exp = {2'b00, 2'b00, 8'h00};
        tv[3].v = mk(3, 1, 5, 1, 5, 3, 0, 0, 0, 0, 0, 0, 1);
        tv[3].exp = {2'b01, 2'b10, 8'h00};
        tv[4].v = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0, 0, 1);
        tv[4].exp = {4'b0, 8'b1100_1000};
        tv[5].v = mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 1, 0, 1);
        tv[5].exp = {4'b0, 8'b0010_1000};
        tv[6].v = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
        tv[6].exp = {4'b0, 8'h00};
        tv[7].v = mk(0, 0, 0, 0, 0, 0, 1, 5, 5, 0, 1, 1, 0);
        tv[7].exp = {4'b0, 8'b1101_0110};
        tv[8].v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        tv[8].exp = {4'b0, 8'b0010_1000};

        rst = 1'b1;
        drive(idle());
        do_reset();

        // Single load-use bubble
        v = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0, 0, 1);
        cyc(v, "lu");
        apply(idle(), "lu_after");
        chk("lu_stall_cnt", 32'(stall_cycles), 32'd1);
        tick(idle());

        for (int i = 0; i < 9; i++) begin
            apply(tv[i].v, $sformatf("tv%0d", i));
            chk($sformatf("tv%0d_tab", i), 32'(dout()),
                32'(tv[i].exp));
            tick(tv[i].v);
        end

        // Memory wait timeout
        do_reset();
        v = idle(); v.mreq = 1; v.rdy = 0;
        for (int i = 0; i < MT; i++) begin
            apply(v, "mw");
            if (i == MT - 1)
                chk("mw_to_pre", 32'(mem_timeout), 32'd0);
            tick(v);
        end
        v.rdy = 1;
        apply(v, "mw_done");
        chk("mw_to_set", 32'(mem_timeout), 32'd1);
        tick(v);
        cyc(idle(), "mw_hold");
        chk("mw_to_hold", 32'(mem_timeout), 32'd1);

        // Halt with a branch on the first drain cycle
        do_reset();
        v = idle(); v.halt = 1;
        cyc(v, "h_run");
        v.br = 1;
        apply(v, "h_d1");
        chk("h_d1_pc", 32'(pc_stall), 32'd0);
        tick(v);
        v.br = 0;
        cyc(v, "h_d2");
        v.halt = 0;
        apply(v, "h_d3");
        chk("h_d3_halted", 32'(halted), 32'd0);
        tick(v);
        apply(v, "h_hlt");
        chk("h_halted", 32'(halted), 32'd1);
        tick(v);
        apply(v, "h_resume");
        chk("h_resumed", 32'(halted), 32'd0);
        tick(v);

        // Asynchronous reset in the middle of a drain
        do_reset();
        v = mk(0, 0, 0, 0, 0, 0, 1, 5, 0, 5, 0, 0, 1);
        for (int i = 0; i < 7; i++) cyc(v, "r_lu");
        v = idle(); v.halt = 1;
        cyc(v, "r_run");
        cyc(v, "r_d1");
        cyc(v, "r_d2");
        chk("r_pre_cnt", 32'(stall_cycles), 32'd9);
        #2;
        rst = 1'b1;
        #1;
        chk("r_cnt", 32'(stall_cycles), 32'd0);
        chk("r_halted", 32'(halted), 32'd0);
        chk("r_pc", 32'(pc_stall), 32'd0);
        model_reset();
        drive(idle());
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply(v, "r_after");
        tick(v);

        // Randomized traffic
        do_reset();
        v = idle();
        for (int i = 0; i < 3000; i++) begin
            v.me_rd = 5'($urandom_range(0, 3));
            v.wb_rd = 5'($urandom_range(0, 3));
            v.ex_rs1 = 5'($urandom_range(0, 3));
            v.ex_rs2 = 5'($urandom_range(0, 3));
            v.ex_rd = 5'($urandom_range(0, 3));
            v.id_rs1 = 5'($urandom_range(0, 3));
            v.id_rs2 = 5'($urandom_range(0, 3));
            v.me_w = 1'($urandom);
            v.wb_w = 1'($urandom);
            v.ex_mr = 1'($urandom);
            v.br = ($urandom_range(0, 5) == 0);
            v.mreq = 1'($urandom);
            v.rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) v.halt = !v.halt;
            cyc(v, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
